// File: rtl/dram_cmd_pkg.sv
// rtl/dram_cmd_pkg.sv - shared command, row-status, state and address types for dram_cmd_seq
package dram_cmd_pkg;

    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6
    } cmd_t;

    typedef enum logic [1:0] {
        ROW_NONE     = 2'b00,
        ROW_HIT      = 2'b01,
        ROW_MISS     = 2'b10,
        ROW_CONFLICT = 2'b11
    } row_stat_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT_STAT,
        S_PRE,
        S_WAIT_RP,
        S_ACT,
        S_WAIT_RCD,
        S_CAS,
        S_REF_PREA,
        S_WAIT_RP_REF,
        S_REF,
        S_WAIT_RFC
    } state_t;

    typedef struct packed {
        logic [1:0]  bank_group;
        logic [1:0]  bank;
        logic [15:0] row;
    } addr_t;

endpackage

// File: rtl/dram_timer.sv
// rtl/dram_timer.sv - loadable down-counter flagging the last cycle of a timing wait
module dram_timer
    import dram_cmd_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               load,
    output logic               expire
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TIMER_W'(1);
        end
    end

    // Loaded with T-1 on the command cycle, so a count of one marks the final wait cycle.
    assign expire = (count <= TIMER_W'(1));

endmodule

// File: rtl/dram_cmd_seq.sv
// rtl/dram_cmd_seq.sv - DRAM command sequencer (ACT/PRE/RD/WR), refresh engine under DRAM_REFRESH_EN
module dram_cmd_seq
    import dram_cmd_pkg::*;
#(
    parameter int T_RCD  = 4,
    parameter int T_RP   = 3,
    parameter int T_RFC  = 16,
    parameter int T_REFI = 1024
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_bank_group,
    input  logic [1:0]  req_bank,
    input  logic [15:0] req_row,
    output logic        pol_req_en,
    output logic [1:0]  pol_bank_group,
    output logic [1:0]  pol_bank,
    output logic [15:0] pol_row,
    output logic        pol_row_resolve,
    output logic        pol_refresh,
    input  logic [1:0]  pol_row_stat,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic [1:0]  cmd_bank_group,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_row,
    output logic        done
);

    localparam logic [TIMER_W-1:0] RP_LD  = TIMER_W'(T_RP - 1);
    localparam logic [TIMER_W-1:0] RCD_LD = TIMER_W'(T_RCD - 1);
    localparam logic [TIMER_W-1:0] RFC_LD = TIMER_W'(T_RFC - 1);

    // Every wait passes through at least one wait state, so each timing value must be at least 2.
    if (T_RCD < 2 || T_RP < 2 || T_RFC < 2 || T_REFI < 2 || T_REFI > 65536) begin : g_param_check
        $error("dram_cmd_seq: timing parameter out of range");
    end

    state_t             state_q, state_d;
    addr_t              addr_q;
    logic               write_q;
    logic               ref_pend;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_expire;
    cmd_t               cmd_sel;
    addr_t              cmd_addr;
    addr_t              pol_addr;

    assign req_ready = (state_q == S_IDLE) && !ref_pend;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_valid && req_ready) begin
                addr_q  <= {req_bank_group, req_bank, req_row};
                write_q <= req_write;
            end
        end
    end

`ifdef DRAM_REFRESH_EN
    localparam logic [TIMER_W-1:0] REFI_LD = TIMER_W'(T_REFI - 1);
    logic [TIMER_W-1:0] refi_cnt;

    // The interval counter free-runs; pending is a single flag so expiries never stack.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            refi_cnt <= REFI_LD;
            ref_pend <= 1'b0;
        end else if (refi_cnt == '0) begin
            refi_cnt <= REFI_LD;
            ref_pend <= 1'b1;
        end else begin
            refi_cnt <= refi_cnt - TIMER_W'(1);
            if (state_q == S_IDLE && ref_pend) begin
                ref_pend <= 1'b0;
            end
        end
    end

    assign pol_refresh = (state_q == S_REF_PREA);
`else
    assign ref_pend    = 1'b0;
    assign pol_refresh = 1'b0;
`endif

    always_comb begin
        tmr_load = 1'b1;
        tmr_val  = '0;
        case (state_q)
            S_PRE, S_REF_PREA: tmr_val = RP_LD;
            S_ACT:             tmr_val = RCD_LD;
            S_REF:             tmr_val = RFC_LD;
            default:           tmr_load = 1'b0;
        endcase
    end

    dram_timer u_timer (
        .clk      (CLK),
        .resetn   (nRST),
        .load_val (tmr_val),
        .load     (tmr_load),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifdef DRAM_REFRESH_EN
                if (ref_pend) state_d = S_REF_PREA;
                else
`endif
                if (req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP:    state_d = S_WAIT_STAT;
            S_WAIT_STAT: begin
                case (row_stat_t'(pol_row_stat))
                    ROW_HIT:      state_d = S_CAS;
                    ROW_MISS:     state_d = S_ACT;
                    ROW_CONFLICT: state_d = S_PRE;
                    default:      state_d = S_LOOKUP;
                endcase
            end
            S_PRE:       state_d = S_WAIT_RP;
            S_WAIT_RP:   if (tmr_expire) state_d = S_LOOKUP;
            S_ACT:       state_d = S_WAIT_RCD;
            S_WAIT_RCD:  if (tmr_expire) state_d = S_CAS;
            S_CAS:       state_d = S_IDLE;
`ifdef DRAM_REFRESH_EN
            S_REF_PREA:    state_d = S_WAIT_RP_REF;
            S_WAIT_RP_REF: if (tmr_expire) state_d = S_REF;
            S_REF:         state_d = S_WAIT_RFC;
            S_WAIT_RFC:    if (tmr_expire) state_d = S_IDLE;
`endif
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid  = 1'b0;
        cmd_sel    = CMD_NOP;
        cmd_addr   = '0;
        done       = 1'b0;
        pol_req_en = 1'b0;
        pol_addr   = '0;
        case (state_q)
            S_LOOKUP: begin
                pol_req_en = 1'b1;
                pol_addr   = addr_q;
            end
            S_PRE: begin
                cmd_valid = 1'b1;
                cmd_sel   = CMD_PRE;
                cmd_addr  = addr_q;
            end
            S_ACT: begin
                cmd_valid = 1'b1;
                cmd_sel   = CMD_ACT;
                cmd_addr  = addr_q;
            end
            S_CAS: begin
                cmd_valid = 1'b1;
                cmd_sel   = write_q ? CMD_WR : CMD_RD;
                cmd_addr  = addr_q;
                done      = 1'b1;
            end
            S_REF_PREA: begin
                cmd_valid = 1'b1;
                cmd_sel   = CMD_PREA;
            end
            S_REF: begin
                cmd_valid = 1'b1;
                cmd_sel   = CMD_REF;
            end
            default: ;
        endcase
    end

    assign cmd_code        = cmd_sel;
    assign cmd_bank_group  = cmd_addr.bank_group;
    assign cmd_bank        = cmd_addr.bank;
    assign cmd_row         = cmd_addr.row;
    assign pol_bank_group  = pol_addr.bank_group;
    assign pol_bank        = pol_addr.bank;
    assign pol_row         = pol_addr.row;
    assign pol_row_resolve = 1'b0;

endmodule

// File: tb/tb_dram_cmd_seq.sv
// tb/tb_dram_cmd_seq.sv - randomized bench for dram_cmd_seq against a timeline reference model
module tb_dram_cmd_seq;

    localparam int T_RCD  = 4;
    localparam int T_RP   = 3;
    localparam int T_RFC  = 16;
    localparam int T_REFI = 64;
    localparam int N_CYC  = 4000;
`ifdef DRAM_REFRESH_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    localparam logic [2:0] C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6;
    localparam logic [1:0] ST_HIT = 2'b01, ST_MISS = 2'b10, ST_CONF = 2'b11;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_bank_group, req_bank;
    logic [15:0] req_row;
    logic        pol_req_en, pol_row_resolve, pol_refresh;
    logic [1:0]  pol_bank_group, pol_bank, pol_row_stat;
    logic [15:0] pol_row;
    logic        cmd_valid, done;
    logic [2:0]  cmd_code;
    logic [1:0]  cmd_bank_group, cmd_bank;
    logic [15:0] cmd_row;

    always #5 CLK = ~CLK;

    dram_cmd_seq #(
        .T_RCD (T_RCD), .T_RP (T_RP), .T_RFC (T_RFC), .T_REFI (T_REFI)
    ) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_bank_group  (req_bank_group),
        .req_bank        (req_bank),
        .req_row         (req_row),
        .pol_req_en      (pol_req_en),
        .pol_bank_group  (pol_bank_group),
        .pol_bank        (pol_bank),
        .pol_row         (pol_row),
        .pol_row_resolve (pol_row_resolve),
        .pol_refresh     (pol_refresh),
        .pol_row_stat    (pol_row_stat),
        .cmd_valid       (cmd_valid),
        .cmd_code        (cmd_code),
        .cmd_bank_group  (cmd_bank_group),
        .cmd_bank        (cmd_bank),
        .cmd_row         (cmd_row),
        .done            (done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Expected activity keyed by cycle; absent keys mean idle outputs.
    logic [23:0] exp_cmd [int];
    logic [22:0] exp_pol [int];
    bit          exp_done [int];
    bit          exp_lk [int];
    logic [1:0]  plan [$];

    int free_at  = 0;
    int rst_base = 0;
    int rst_at   = -1;
    bit pend     = 1'b0;
    bit idle;

    bit          have_req = 1'b0;
    logic        r_write;
    logic [1:0]  r_bg, r_bk;
    logic [15:0] r_row;
    logic [1:0]  r_plan [$];
    bit          r_rst;

    int   dir_kind  [6] = '{0, 1, 2, 5, 3, 4};
    logic dir_write [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   dir_idx = 0;

    task automatic new_req(input int kind, input logic wr);
        r_write = wr;
        r_bg    = 2'($urandom);
        r_bk    = 2'($urandom);
        r_row   = 16'($urandom);
        r_rst   = 1'b0;
        r_plan.delete();
        case (kind)
            0: r_plan.push_back(ST_HIT);
            1: r_plan.push_back(ST_MISS);
            2: begin r_plan.push_back(ST_CONF); r_plan.push_back(ST_MISS); end
            3: begin r_plan.push_back(2'b00); r_plan.push_back(ST_CONF); r_plan.push_back(ST_MISS); end
            4: begin repeat (70) r_plan.push_back(2'b00); r_plan.push_back(ST_HIT); end
            default: begin r_plan.push_back(ST_MISS); r_rst = 1'b1; end
        endcase
        have_req = 1'b1;
    endtask

    task automatic schedule_txn(input int a);
        int l = a + 1;
        int cas = 0;
        int act = 0;
        foreach (r_plan[i]) begin
            exp_pol[l] = {1'b1, r_bg, r_bk, r_row, 1'b0, 1'b0};
            exp_lk[l]  = 1'b1;
            case (r_plan[i])
                2'b00: l = l + 2;
                ST_CONF: begin
                    exp_cmd[l + 2] = {1'b1, C_PRE, r_bg, r_bk, r_row};
                    l = l + 2 + T_RP;
                end
                ST_MISS: begin
                    act = l + 2;
                    exp_cmd[act] = {1'b1, C_ACT, r_bg, r_bk, r_row};
                    cas = act + T_RCD;
                end
                default: cas = l + 2;
            endcase
        end
        exp_cmd[cas]  = {1'b1, (r_write ? C_WR : C_RD), r_bg, r_bk, r_row};
        exp_done[cas] = 1'b1;
        free_at = cas + 1;
        if (r_rst) rst_at = act + 1;
        plan = r_plan;
    endtask

    initial begin
        nRST = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_bank_group = '0;
        req_bank = '0;
        req_row = '0;
        pol_row_stat = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int c = 0; c < N_CYC; c++) begin
            cyc = c;
            if (REF_EN && c > rst_base && (c - rst_base) % T_REFI == 0) pend = 1'b1;
            idle = (c >= free_at);

            check("req_ready", 32'(req_ready), 32'(idle && !pend));
            check("cmd", 32'({cmd_valid, cmd_code, cmd_bank_group, cmd_bank, cmd_row}),
                  32'(exp_cmd.exists(c) ? exp_cmd[c] : 24'h0));
            check("done", 32'(done), 32'(exp_done.exists(c)));
            check("pol", 32'({pol_req_en, pol_bank_group, pol_bank, pol_row, pol_refresh, pol_row_resolve}),
                  32'(exp_pol.exists(c) ? exp_pol[c] : 23'h0));

            // Tracker answers one cycle after each lookup; otherwise the status lines carry noise.
            if (exp_lk.exists(c - 1) && plan.size() > 0) pol_row_stat = plan.pop_front();
            else pol_row_stat = 2'($urandom_range(0, 3));
            nRST = (c == rst_at) ? 1'b0 : 1'b1;

            if (!have_req && $urandom_range(0, 2) == 0) begin
                if (dir_idx < 6) begin
                    new_req(dir_kind[dir_idx], dir_write[dir_idx]);
                    dir_idx++;
                end else begin
                    new_req(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                end
            end
            req_valid = have_req;
            if (have_req) begin
                req_write = r_write;
                req_bank_group = r_bg;
                req_bank = r_bk;
                req_row = r_row;
            end else begin
                req_write = 1'($urandom);
                req_bank_group = 2'($urandom);
                req_bank = 2'($urandom);
                req_row = 16'($urandom);
            end

            if (!nRST) begin
                for (int k = c + 1; k < c + 400; k++) begin
                    exp_cmd.delete(k);
                    exp_pol.delete(k);
                    exp_done.delete(k);
                    exp_lk.delete(k);
                end
                plan.delete();
                free_at  = c + 1;
                pend     = 1'b0;
                rst_base = c + 1;
            end else if (idle && pend) begin
                exp_cmd[c + 1]        = {1'b1, C_PREA, 20'h0};
                exp_pol[c + 1]        = 23'h2;
                exp_cmd[c + 1 + T_RP] = {1'b1, C_REF, 20'h0};
                free_at = c + 1 + T_RP + T_RFC;
                pend = 1'b0;
            end else if (idle && have_req) begin
                schedule_txn(c);
                have_req = 1'b0;
            end
            @(negedge CLK);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
